// File: rtl/serial_fir_pkg.sv
// Shared types and constants for the serial FIR, its sample feeder and bench.
package serial_fir_pkg;

   typedef enum logic {ST_IDLE, ST_RUN} feeder_state_e;

   localparam int FIR_DATA_W   = 12;
   localparam int FIR_SLOT_LEN = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; push when full and pop when empty are ignored.
module sync_fifo #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage carries no reset; only pointers and occupancy are control state.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            level <= level + 1'b1;
         end else if (!push_ok && pop_ok) begin
            level <= level - 1'b1;
         end
      end
   end

endmodule

// File: rtl/serial_fir_feeder.sv
// Buffers incoming samples and issues them to the serial FIR as one-cycle strobes on a fixed slot cadence.
module serial_fir_feeder
   import serial_fir_pkg::*;
#(
   parameter int DATA_W     = FIR_DATA_W,
   parameter int SLOT_LEN   = FIR_SLOT_LEN,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        s_valid_i,
   output logic                        s_ready_o,
   input  logic [DATA_W-1:0]           s_data_i,
   output logic                        enable_o,
   output logic [DATA_W-1:0]           data_o,
   output logic [$clog2(FIFO_DEPTH):0] level_o,
   output logic                        underrun_o
);

   localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

   feeder_state_e     state;
   feeder_state_e     state_nxt;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nxt;
   logic              pop;
   logic              push;
   logic              underrun_nxt;
   logic              slot_end;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] head;

   // Readiness depends only on registered occupancy, so a same-edge pop never frees a full FIFO.
   assign s_ready_o = !rst_i && !fifo_full;
   assign push      = s_valid_i && s_ready_o;
   assign slot_end  = (cnt == CW'(SLOT_LEN - 1));

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push),
      .pop   (pop),
      .wdata (s_data_i),
      .head  (head),
      .level (level_o),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pop          = 1'b0;
      underrun_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // Once running the slot phase is free-running and never re-aligned to arrivals.
            if (slot_end) begin
               cnt_nxt = '0;
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  underrun_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         enable_o   <= 1'b0;
         underrun_o <= 1'b0;
         data_o     <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         enable_o   <= pop;
         underrun_o <= underrun_nxt;
         if (pop) begin
            data_o <= head;
         end
      end
   end

endmodule

// File: tb/tb_serial_fir_feeder.sv
// Directed bench for serial_fir_feeder: a scoreboard queue models the FIFO and the slot cadence.
module tb_serial_fir_feeder;
   import serial_fir_pkg::*;

   localparam int DW = FIR_DATA_W;
   localparam int SL = FIR_SLOT_LEN;
   localparam int FD = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic          enable;
   logic [DW-1:0] data;
   logic [3:0]    level;
   logic          underrun;

   always #5 clk = ~clk;

   serial_fir_feeder #(
      .DATA_W     (DW),
      .SLOT_LEN   (SL),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .s_valid_i  (s_valid),
      .s_ready_o  (s_ready),
      .s_data_i   (s_data),
      .enable_o   (enable),
      .data_o     (data),
      .level_o    (level),
      .underrun_o (underrun)
   );

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic [DW-1:0] q[$];
   bit            m_run = 0;
   int            m_cnt = 0;
   bit            exp_en = 0;
   bit            exp_und = 0;
   logic [DW-1:0] m_data = '0;
   int            n_en = 0;
   int            n_und = 0;
   int            last_en = 0;
   bit            accepted = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge: advance the reference model, then compare every DUT output.
   task automatic step();
      bit            pre_rst;
      bit            pre_push;
      bit            pre_ne;
      logic [DW-1:0] pre_data;
      pre_rst  = rst;
      pre_ne   = (q.size() != 0);
      pre_push = s_valid && !rst && (q.size() < FD);
      pre_data = s_data;
      @(posedge clk);
      #1;
      cyc++;
      accepted = pre_push;
      exp_en   = 0;
      exp_und  = 0;
      if (pre_rst) begin
         q.delete();
         m_run   = 0;
         m_cnt   = 0;
         m_data  = '0;
         last_en = 0;
      end else begin
         if (!m_run) begin
            if (pre_ne) begin
               exp_en = 1;
               m_run  = 1;
               m_cnt  = 0;
            end
         end else if (m_cnt == SL - 1) begin
            m_cnt = 0;
            if (pre_ne) exp_en = 1;
            else        exp_und = 1;
         end else begin
            m_cnt++;
         end
         if (exp_en) m_data = q.pop_front();
         if (pre_push) q.push_back(pre_data);
      end
      if (exp_en)  n_en++;
      if (exp_und) n_und++;
      chk("enable", enable, exp_en);
      chk("underrun", underrun, exp_und);
      chk("data", data, m_data);
      chk("level", level, q.size());
      chk("ready", s_ready, (!rst && q.size() < FD));
      if (enable === 1'b1 && exp_en) begin
         if (last_en != 0) chk("spacing", (cyc - last_en) % SL, 0);
         last_en = cyc;
      end
   endtask

   initial begin
      int acc_cyc[11];
      int g;
      int k;

      // Reset held for 10 cycles.
      rst = 1'b1;
      repeat (10) step();
      chk("rst_ready", s_ready, 0);
      chk("rst_enable", enable, 0);
      chk("rst_data", data, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_level", level, 0);
      rst = 1'b0;
      step();
      chk("ready_after_rst", s_ready, 1);
      repeat (5) step();
      chk("idle_no_strobe", n_en, 0);

      // Single sample: strobe in the cycle after the edge following acceptance.
      s_valid = 1'b1;
      s_data  = 12'h5A3;
      step();
      chk("acc_5a3", s_ready, 1);
      s_valid = 1'b0;
      step();
      chk("first_strobe", enable, 1);
      chk("first_data", data, 12'h5A3);
      step();
      chk("strobe_width", enable, 0);
      n_und = 0;
      repeat (48) step();
      chk("underrun_count", n_und, 3);
      chk("data_hold", data, 12'h5A3);

      // Burst 1..10: first push one edge before a boundary.
      g = 0;
      while (m_cnt != SL - 2 && g < 40) begin step(); g++; end
      n_en = 0;
      n_und = 0;
      s_valid = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         s_data = DW'(i);
         g = 0;
         do begin step(); g++; end while (!accepted && g < 64);
         if (!accepted) chk("burst_accept_timeout", 0, 1);
         acc_cyc[i] = cyc;
         if (i == 9) chk("ready_fall_after_9", s_ready, 0);
      end
      s_valid = 1'b0;
      chk("gap_9_to_10", acc_cyc[10] - acc_cyc[9], 10);
      g = 0;
      while (n_en < 10 && g < 300) begin step(); g++; end
      chk("burst_strobes", n_en, 10);
      chk("burst_no_underrun", n_und, 0);
      chk("burst_last_data", data, 10);

      // Full FIFO at a slot boundary with valid held high.
      s_valid = 1'b1;
      for (int i = 0; i < FD; i++) begin
         s_data = DW'(12'h100 + i);
         step();
      end
      chk("full_level", level, 8);
      chk("full_ready", s_ready, 0);
      s_data = 12'h1FF;
      g = 0;
      while (m_cnt != SL - 1 && g < 40) begin step(); g++; end
      step();
      chk("boundary_pop", enable, 1);
      chk("boundary_no_push_level", level, 7);
      step();
      chk("push_after_boundary_level", level, 8);
      s_valid = 1'b0;

      // Underrun, then a sample pushed mid-slot waits for the next boundary.
      g = 0;
      do begin step(); g++; end while (underrun !== 1'b1 && g < 400);
      chk("underrun_seen", underrun, 1);
      g = 0;
      while (m_cnt != 5 && g < 40) begin step(); g++; end
      s_valid = 1'b1;
      s_data  = 12'h0FF;
      step();
      s_valid = 1'b0;
      // Push edge sees cnt=5; the wrap edge is the one seeing cnt=15, ten edges on.
      k = 0;
      while (enable !== 1'b1 && k < 20) begin step(); k++; end
      chk("resume_delay", k, 10);
      chk("resume_data", data, 12'h0FF);

      // Reset with five samples buffered.
      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_data = DW'(12'h200 + i);
         step();
      end
      s_valid = 1'b0;
      chk("pre_reset_level", level, 5);
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      n_en = 0;
      repeat (40) step();
      chk("no_stale_strobe", n_en, 0);
      chk("post_reset_level", level, 0);
      s_valid = 1'b1;
      s_data  = 12'hABC;
      step();
      s_valid = 1'b0;
      step();
      chk("post_reset_strobe", enable, 1);
      chk("post_reset_data", data, 12'hABC);
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
